re_matcher: RTL and testbench
=============================

Name: re_matcher

Overview:
- Streaming byte-at-a-time regular-expression matcher, one character per clock, no backpressure.
- The pattern is hard-wired into the block: `Hel+o, world!`, unanchored, searched continuously over an unbounded byte stream.
- Implemented as a one-hot NFA state register.
- Output is a single-cycle pulse each time a match completes; it feeds the regex accelerator's match/event logic.

Parameters:
- None. Pattern and 8-bit character width are fixed in RTL.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset; clears all NFA state and match.
- c  input  8  current stream byte (ASCII), sampled every rising edge; a new byte every cycle.
- match  output  1  registered; high for one cycle when the byte sampled on the previous edge completed the pattern.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Pattern elements, in order:
  - 'H', 'e'
  - 'l' repeated one or more times
  - 'o', ',', ' ', 'w', 'o', 'r', 'l', 'd', '!'
  - Exact byte compare; no wildcards, no anchors.
- State: 11-bit one-hot-per-position register s[10:0]; s[i] = "prefix through element i matched, ending at last byte".
- Next-state, evaluated each edge with byte c:
  - s0' = (c=='H'). The start state is always active, so matches may begin at any byte, including overlapping attempts.
  - s1' = s0 & (c=='e').
  - s2' = (s1 | s2) & (c=='l'). This is the self-loop for l+.
  - s3' = s2 & (c=='o'), s4' = s3 & (c==','), s5' = s4 & (c==' '), s6' = s5 & (c=='w').
  - s7' = s6 & (c=='o'), s8' = s7 & (c=='r'), s9' = s8 & (c=='l'), s10' = s9 & (c=='d').
  - match' = s10 & (c=='!').
- Any non-continuing byte drops that thread; other active threads are unaffected.
- Latency: the byte completing the match is sampled at edge N; match is high from edge N until edge N+1, i.e. exactly one cycle.
- Repeated terminators ("!!") produce one pulse only; the second '!' does not re-match.
- Back-to-back matches pulse on consecutive completions; there is no dead time.
- Reset:
  - While rst=1 at an edge, s and match are cleared to 0 and c is ignored.
  - Reset mid-match discards partial progress.
  - The first byte after reset deasserts is evaluated normally.
- Unknown/X on c during reset must not propagate: reset has priority.
- NUL (0x00) and every other byte outside the pattern simply kills threads.

Optional Feature:
- Macro RE_CASE_FOLD_EN.
- When defined: ASCII letters A–Z/a–z compare case-insensitively, by folding c to lowercase before the compare and using lowercase pattern constants. "hELLo, WORLD!" then matches.
- When undefined: exact byte compare as above. Non-letter bytes are identical in both builds.

Test Plan:
- Reset: hold rst=1 for 3 cycles while driving 'H','e','l' -> match=0 throughout; then release and drive "lo, world!" -> no match, because the prefix was discarded.
- Primary stream: after reset, drive "Hello, world!! Helo world! Helllo, world!!" (indices 0–41) then 0x00. Required response:
  - match pulses exactly twice, one cycle each.
  - First pulse is the cycle after index 12 is sampled.
  - Second pulse is the cycle after index 40 is sampled.
  - No pulse for "Helo world!" (missing comma) or for indices 13/41.
- l+ boundary: "Heo, world!" -> no match; "Hello, world!" and "Hellllllllo, world!" -> one pulse each.
- Overlap/restart: "HHello, world!" and "Hello, Hello, world!" -> exactly one pulse each, at the final '!'.
- Back-to-back: "Hello, world!Hello, world!" with no gap -> two pulses, 13 cycles apart.
- Case: "HELLO, WORLD!" -> no pulse without RE_CASE_FOLD_EN; one pulse with it.

Source files
------------

// File: rtl/re_matcher_if.sv
// re_matcher_if: byte stream in, match pulse out.
interface re_matcher_if;
    logic [7:0] c;
    logic       match;
    modport master (output c, input match);
    modport slave  (input c, output match);
endinterface

// File: rtl/re_matcher.sv
// re_matcher: one-hot NFA streaming search for "Hel+o, world!", one byte per clock.
// Define RE_CASE_FOLD_EN to compare ASCII letters case-insensitively.
module re_matcher (
    input  logic           clk,
    input  logic           rst,
    re_matcher_if.slave    bus
);
    logic [10:0] s_q, s_d;
    logic        match_q, match_d;
    logic [7:0]  cf;
    logic [7:0]  ch_h, ch_w;
`ifdef RE_CASE_FOLD_EN
    // Fold upper-case letters onto lower case; pattern letters are then lower case.
    assign cf   = (bus.c >= 8'h41 && bus.c <= 8'h5a) ? (bus.c | 8'h20) : bus.c;
    assign ch_h = 8'h68;
    assign ch_w = 8'h77;
`else
    assign cf   = bus.c;
    assign ch_h = 8'h48;
    assign ch_w = 8'h57 | 8'h20;
`endif

    always_comb begin
        s_d[0]  = cf == ch_h;
        s_d[1]  = s_q[0] & (cf == 8'h65);
        s_d[2]  = (s_q[1] | s_q[2]) & (cf == 8'h6c);
        s_d[3]  = s_q[2] & (cf == 8'h6f);
        s_d[4]  = s_q[3] & (cf == 8'h2c);
        s_d[5]  = s_q[4] & (cf == 8'h20);
        s_d[6]  = s_q[5] & (cf == ch_w);
        s_d[7]  = s_q[6] & (cf == 8'h6f);
        s_d[8]  = s_q[7] & (cf == 8'h72);
        s_d[9]  = s_q[8] & (cf == 8'h6c);
        s_d[10] = s_q[9] & (cf == 8'h64);
        match_d = s_q[10] & (cf == 8'h21);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            match_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            match_q <= match_d;
        end
    end

    assign bus.match = match_q;
endmodule

// File: tb/tb_re_matcher.sv
// tb_re_matcher: directed byte streams; driver queues expected match per byte, monitor compares each cycle.
module tb_re_matcher;
    logic clk = 1'b0;
    logic rst = 1'b1;
    re_matcher_if bus();
    re_matcher dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    bit    exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    failures = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            automatic bit    e = exp_q.pop_front();
            automatic string t = tag_q.pop_front();
            checks++;
            if (bus.match !== e) begin
                failures++;
                $display("FAIL %s: match got %b expected %b", t, bus.match, e);
            end
        end
    end

    task automatic drive(input logic [7:0] b, input logic r, input bit e, input string t);
        @(negedge clk);
        bus.c = b;
        rst   = r;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    // p1/p2: byte indices whose sampling must produce a pulse; -1 for none.
    task automatic send(input string s, input int p1, input int p2, input string t);
        for (int i = 0; i < s.len(); i++)
            drive(s[i], 1'b0, (i == p1) || (i == p2), $sformatf("%s[%0d]", t, i));
        drive(8'h00, 1'b0, 1'b0, {t, "_nul"});
    endtask

    initial begin
        string pre;
        bus.c = 8'h00;
        drive(8'h00, 1'b1, 1'b0, "reset0");
        pre = "Hel";
        for (int i = 0; i < 3; i++) drive(pre[i], 1'b1, 1'b0, $sformatf("reset_hold[%0d]", i));
        send("lo, world!", -1, -1, "post_reset");
        send("Hello, world!! Helo world! Helllo, world!!", 12, 40, "primary");
        send("Heo, world!", -1, -1, "no_l");
        send("Hello, world!", 12, -1, "ll");
        send("Hellllllllo, world!", 18, -1, "many_l");
        send("HHello, world!", 13, -1, "double_h");
        send("Hello, Hello, world!", 19, -1, "restart");
        send("Hello, world!Hello, world!", 12, 25, "back2back");
        send("Hello, wor", -1, -1, "mid_pre");
        drive("l", 1'b1, 1'b0, "mid_reset");
        send("d!", -1, -1, "mid_post");
`ifdef RE_CASE_FOLD_EN
        send("HELLO, WORLD!", 12, -1, "upper");
        send("hELLo, WORLD!", 12, -1, "mixed");
`else
        send("HELLO, WORLD!", -1, -1, "upper");
        send("hELLo, WORLD!", -1, -1, "mixed");
`endif
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
